// File: rtl/ram_arbiter.sv
// Round-robin two-requester access controller for the single-port latch RAM.
// Each access runs through setup, enable and hold phases so the address and data stay stable around the latch enable.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]            r_state;
    logic                  r_last;
    logic                  r_sel;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_ramWe;

    logic [2:0]            w_next;
    logic                  w_accept;
    logic                  w_pick;
    logic                  w_nextSel;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_accept  = req0 | req1;
        w_pick    = (req0 & req1) ? ~r_last : req1;
        w_nextSel = (r_state == ST_IDLE) ? w_pick : r_sel;
        w_next    = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = w_accept ? ST_SETUP : ST_IDLE;
            ST_SETUP: w_next = r_we ? ST_WRITE : ST_READ;
            ST_WRITE: w_next = ST_HOLD;
            ST_HOLD:  w_next = ST_DONE;
            ST_READ:  w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DONE) begin
                r_last <= r_sel;
            end
        end
    end

    // The request is frozen here; the requester may change or drop it afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_sel   <= w_pick;
            r_we    <= w_pick ? we1 : we0;
            r_addr  <= w_pick ? addr1 : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ST_READ) begin
            if (r_sel) begin
                r_rdata1 <= ram_dout;
            end else begin
                r_rdata0 <= ram_dout;
            end
        end
    end

    // Control outputs come straight from flops so the latch enable never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_ramWe <= 1'b0;
        end else begin
            r_gnt0  <= (w_next != ST_IDLE) && !w_nextSel;
            r_gnt1  <= (w_next != ST_IDLE) && w_nextSel;
            r_ack0  <= (w_next == ST_DONE) && !w_nextSel;
            r_ack1  <= (w_next == ST_DONE) && w_nextSel;
            r_ramWe <= (w_next == ST_WRITE);
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign ram_we   = r_ramWe;
    assign ram_addr = r_addr;
    assign ram_din  = r_wdata;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM plus a transaction-level model of expected memory and read data.
// Directed scenarios, random single accesses, held-request streams and a reset in the middle of a write.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] ramAddr;
    logic [7:0] ramDin;
    logic       ramWe;
    logic [7:0] ramDout;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] refMem [16];
    logic [7:0] expRdata [2];
    int         checks = 0;
    int         errors = 0;

    ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ramAddr), .ram_din(ramDin), .ram_we(ramWe), .ram_dout(ramDout)
    );

    always #5 clk = ~clk;

    // The RAM array itself: combinational read, write while the enable is high.
    assign ramDout = mem[ramAddr];
    always @(posedge clk) if (ramWe) mem[ramAddr] <= ramDin;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic gntOf(input bit port);
        return port ? gnt1 : gnt0;
    endfunction

    function automatic logic ackOf(input bit port);
        return port ? ack1 : ack0;
    endfunction

    function automatic logic [7:0] rdataOf(input bit port);
        return port ? rdata1 : rdata0;
    endfunction

    task automatic drivePort(input bit port, input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
        if (port) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // The two grants must never be high together outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) checkOutput("gntOverlap", 32'(gnt0 & gnt1), 0);
    end

    // One access on an otherwise idle arbiter, checked phase by phase from the acceptance edge.
    task automatic applyStimulus(input bit port, input logic weS, input logic [3:0] a, input logic [7:0] d, input bit perturb);
        int         n;
        int         waitCyc;
        logic [7:0] otherBefore;
        n = weS ? 4 : 3;
        otherBefore = expRdata[!port];
        @(negedge clk);
        drivePort(port, 1'b1, weS, a, d);
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (!gntOf(port) && waitCyc < 20);
        checkOutput("grantLatency", waitCyc, 1);
        if (!gntOf(port)) begin
            drivePort(port, 1'b0, weS, a, d);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1 && perturb) drivePort(port, 1'b0, ~weS, a ^ 4'hF, ~d);
            checkOutput("gntOwn", 32'(gntOf(port)), 1);
            checkOutput("gntOther", 32'(gntOf(!port)), 0);
            checkOutput("ramWe", 32'(ramWe), 32'(weS && k == 2));
            checkOutput("ramAddr", 32'(ramAddr), 32'(a));
            checkOutput("ramDin", 32'(ramDin), 32'(d));
            checkOutput("ackOwn", 32'(ackOf(port)), 32'(k == n));
            checkOutput("ackOther", 32'(ackOf(!port)), 0);
            if (k == n && !weS) checkOutput("rdataOwn", 32'(rdataOf(port)), 32'(refMem[a]));
            if (k == n) begin
                checkOutput("rdataOther", 32'(rdataOf(!port)), 32'(otherBefore));
                drivePort(port, 1'b0, weS, a, d);
            end
        end
        if (weS) refMem[a] = d;
        else expRdata[port] = refMem[a];
        @(negedge clk);
        checkOutput("idleGnt", 32'(gnt0 | gnt1), 0);
        checkOutput("idleAck", 32'(ack0 | ack1), 0);
    endtask

    // Requests held continuously: checks service order and ack spacing.
    task automatic streamTest(input logic m0, input logic m1, input logic weS,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input int nAcks, input int period, input bit firstPort);
        int cyc;
        int lastAck;
        int got;
        bit expPort;
        bit port;
        cyc = 0; lastAck = 0; got = 0; expPort = firstPort;
        @(negedge clk);
        drivePort(0, m0, weS, a0, d0);
        drivePort(1, m1, weS, a1, d1);
        while (got < nAcks && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack0 | ack1) begin
                port = ack1;
                checkOutput("streamOrder", 32'(port), 32'(expPort));
                checkOutput("streamSpacing", cyc - lastAck, (got == 0) ? period - 1 : period);
                if (!weS) checkOutput("streamRdata", 32'(rdataOf(port)), 32'(refMem[port ? a1 : a0]));
                lastAck = cyc;
                got++;
                if (m0 && m1) expPort = !expPort;
                if (got == nAcks) begin
                    drivePort(0, 1'b0, weS, a0, d0);
                    drivePort(1, 1'b0, weS, a1, d1);
                end
            end
        end
        if (got < nAcks) begin
            checkOutput("streamTimeout", got, nAcks);
            drivePort(0, 1'b0, weS, a0, d0);
            drivePort(1, 1'b0, weS, a1, d1);
        end
        if (weS) begin
            if (m0) refMem[a0] = d0;
            if (m1) refMem[a1] = d1;
        end else begin
            if (m0) expRdata[0] = refMem[a0];
            if (m1) expRdata[1] = refMem[a1];
        end
        repeat (2) @(negedge clk);
        checkOutput("streamIdle", 32'(gnt0 | gnt1), 0);
    endtask

    initial begin
        int waitCyc;
        for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
        expRdata[0] = 8'h00;
        expRdata[1] = 8'h00;
        rst = 1'b1;
        drivePort(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drivePort(1, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("resetGnt", {gnt1, gnt0}, 0);
        checkOutput("resetAck", {ack1, ack0}, 0);
        checkOutput("resetWe", 32'(ramWe), 0);
        checkOutput("resetAddr", 32'(ramAddr), 0);
        checkOutput("resetDin", 32'(ramDin), 0);
        checkOutput("resetRdata", {rdata1, rdata0}, 0);
        rst = 1'b0;

        $display("[TB] simultaneous writes after reset");
        streamTest(1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22, 4, 5, 1'b0);

        $display("[TB] write then read on requester 0");
        applyStimulus(1'b0, 1'b1, 4'h3, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
        checkOutput("rdata0A5", 32'(rdata0), 32'h A5);

        $display("[TB] read data isolation");
        applyStimulus(1'b1, 1'b1, 4'h5, 8'h3C, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h5, 8'hEE, 1'b0);
        checkOutput("rdata1Isolated", {rdata1, rdata0}, 32'h 3CA5);

        $display("[TB] request changed after acceptance");
        applyStimulus(1'b0, 1'b1, 4'h7, 8'h5A, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h7, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h8, 8'h00, 1'b0);

        $display("[TB] read throughput on requester 1");
        streamTest(1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 8'h00, 8'h00, 4, 4, 1'b1);

        $display("[TB] random single accesses");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during write");
        @(negedge clk);
        drivePort(0, 1'b1, 1'b1, 4'h9, 8'h77);
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (!ramWe && waitCyc < 10);
        checkOutput("weBeforeReset", 32'(ramWe), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncWe", 32'(ramWe), 0);
        checkOutput("asyncGnt", {gnt1, gnt0}, 0);
        checkOutput("asyncAck", {ack1, ack0}, 0);
        checkOutput("asyncAddrDin", {ramAddr, ramDin}, 0);
        checkOutput("asyncRdata", {rdata1, rdata0}, 0);
        expRdata[0] = 8'h00;
        expRdata[1] = 8'h00;
        drivePort(0, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("resetHeldAck", {ack1, ack0}, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'h9, 8'h66, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h9, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
